memory_responder: RTL and testbench
===================================

# memory_responder

Memory-side responder for the CPU controller's memory handshake. Accepts a `read` or `write` request with the word address held in MAR and write data held in MDR, waits a configurable access latency, performs the access on an internal word-addressed array, and raises `MFC` (memory function complete). `MFC` is held until the controller drops its request, giving a full four-phase handshake. It sits between the controller/MAR/MDR datapath and the system bus in place of a behavioural memory model.

## Interface
- `ADDR_WIDTH`, default 8: word address width; the array holds 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 16: word width.
- `LATENCY`, default 3: cycles from request sample to `MFC` rising. Legal range is 1..15.
- `clock` input, 1 bit: clock.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `read` input, 1 bit: read request, level, from the controller.
- `write` input, 1 bit: write request, level, from the controller.
- `addr` input, ADDR_WIDTH bits: word address, from MAR.
- `dataIn` input, DATA_WIDTH bits: write data, from MDR.
- `dataOut` output, DATA_WIDTH bits: read data, registered.
- `MFC` output, 1 bit: memory function complete, registered.
- `busy` output, 1 bit: high in WAIT or ACK.
- `err` output, 1 bit: request-conflict flag, registered.

## Operation
- FSM states: IDLE, WAIT, ACK. A 4-bit down-counter `cnt` runs alongside.
- **IDLE**
  - Exactly one of `read`/`write` sampled high: latch `addr`, `dataIn` and the op; load `cnt = LATENCY-1`; go to WAIT.
  - Both sampled high: `err <= 1` for that cycle; no latch; stay in IDLE.
  - Otherwise `err <= 0`.
- **WAIT**
  - If the latched op's request line is sampled low, abort: go to IDLE with no access and no `MFC`.
  - Else, if `cnt == 0`: perform the access using the latched address and data. A write updates the array. A read loads `dataOut` from the array. Set `MFC <= 1`; go to ACK.
  - Else `cnt <= cnt - 1`.
- **ACK**
  - Hold `MFC = 1`. Hold `dataOut`.
  - When `read` and `write` are both sampled low: `MFC <= 0`; go to IDLE.
  - A request still high, or switching from `read` to `write`, is ignored until both lines are seen low.
- Address and data changes after the IDLE sample are ignored; the latched values are used.
- `dataOut` changes only on a completed read. It keeps its value through writes and idle cycles.
- Array contents are not cleared by reset and are undefined after power-up. Only writes define them.

## Timing
- Reset values: state IDLE, `MFC` 0, `dataOut` 0, `busy` 0, `err` 0, `cnt` 0.
- Reset mid-operation aborts immediately.
  - A write not yet committed is not performed.
  - A write already committed (state ACK) persists.
- Latency: request sampled at edge N gives `MFC` high after edge N+LATENCY. Read data is valid from that same edge.
  - LATENCY=1: WAIT lasts one cycle; the access happens at edge N+1.
- `MFC` falls one edge after both requests are sampled low. The earliest new request is sampled at the next edge after that, from IDLE.
- `busy` is combinational from state; `MFC` and `err` are registered.
- Minimum transaction: LATENCY+2 cycles from request to IDLE, with the controller dropping the request the cycle `MFC` is seen.

## Test plan
- **Write then read, LATENCY=3.**
  - Stimulus: write `addr=0x12`, `dataIn=0xBEEF`.
  - Required: `MFC` rises exactly 3 edges after the sample; drop `write` and `MFC` falls 1 edge later.
  - Stimulus: read `0x12`.
  - Required: `dataOut=0xBEEF` on the `MFC` edge.
- **Held request.** Keep `read` high for 5 cycles after `MFC`.
  - Required: `MFC` stays 1, `dataOut` is stable, and no second access occurs; `MFC` falls 1 edge after `read` drops.
- **Abort.** Write `addr=0x05`, `0x1234`, then drop `write` in WAIT after 1 cycle.
  - Required: no `MFC`; return to IDLE.
  - Then read `0x05` after a prior write of `0xAAAA` to `0x05`. Required: `dataOut=0xAAAA`.
- **Conflict.** Assert `read` and `write` together for 2 cycles.
  - Required: `err=1` for 2 cycles, `busy=0`, no `MFC`, array unchanged.
- **Reset mid-operation.**
  - Pulse `reset` during WAIT of a write of `0x0F0F` to `0x20` (0x20 previously written `0x1111`). Required: all outputs go to their reset values; a later read of `0x20` returns `0x1111`.
  - Pulse `reset` in ACK of a write of `0x2222` to `0x21`. Required: a later read of `0x21` returns `0x2222`.
- **Back-to-back, LATENCY=1.**
  - Stimulus: write `0xFF` then read `0xFF` (top address, `0xC0DE`), each dropped on `MFC`.
  - Required: each `MFC` rises 1 edge after its sample; total of 3 cycles per transaction; `dataOut=0xC0DE`.

Source files
------------

// File: rtl/memory_responder.sv
// Word-addressed memory responder for the controller's four-phase
// read/write handshake with programmable access latency.
module memory_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int LATENCY    = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  MFC,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  op_q, op_d;
  logic                  mfc_q, mfc_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  mem_we;
  logic                  req_live;

  // Next-state, handshake outputs and access strobe
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_d     = op_q;
    mfc_d    = mfc_q;
    err_d    = 1'b0;
    dout_d   = dout_q;
    mem_we   = 1'b0;
    req_live = op_q ? write : read;
    unique case (state_q)
      IDLE: begin
        mfc_d = 1'b0;
        if (read ^ write) begin
          addr_d  = addr;
          data_d  = dataIn;
          op_d    = write;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end else if (read && write) begin
          err_d = 1'b1;
        end
      end
      WAIT: begin
        if (!req_live) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          mfc_d   = 1'b1;
          state_d = ACK;
          if (op_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d = mem[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        if (!read && !write) begin
          mfc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        mfc_d   = 1'b0;
      end
    endcase
  end

  // Control and output registers, synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      data_q  <= '0;
      op_q    <= 1'b0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_q    <= op_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Storage array; a reset on the commit edge suppresses the write
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem[addr_q] <= data_q;
    end
  end

  assign dataOut = dout_q;
  assign MFC     = mfc_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Directed + randomized bench for memory_responder at LATENCY 3 and 1,
// checked against an array-based model of the handshake contract.
module tb_memory_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst [2];
  logic        rd  [2];
  logic        wr  [2];
  logic [7:0]  ad  [2];
  logic [15:0] di  [2];
  logic [15:0] dout[2];
  logic        mfc [2];
  logic        bsy [2];
  logic        er  [2];

  int checks   = 0;
  int failures = 0;
  int lat [2]  = '{3, 1};

  logic [15:0] mem_m  [2][256];
  bit          valid_m[2][256];
  logic [15:0] dout_m [2];

  memory_responder #(.LATENCY(3)) u_l3 (
    .clock(clock), .reset(rst[0]), .read(rd[0]), .write(wr[0]),
    .addr(ad[0]), .dataIn(di[0]), .dataOut(dout[0]),
    .MFC(mfc[0]), .busy(bsy[0]), .err(er[0])
  );

  memory_responder #(.LATENCY(1)) u_l1 (
    .clock(clock), .reset(rst[1]), .read(rd[1]), .write(wr[1]),
    .addr(ad[1]), .dataIn(di[1]), .dataOut(dout[1]),
    .MFC(mfc[1]), .busy(bsy[1]), .err(er[1])
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_outs(int k, logic [15:0] d);
    chk("mfc_idle", 32'(mfc[k]), 0);
    chk("busy_idle", 32'(bsy[k]), 0);
    chk("err_idle", 32'(er[k]), 0);
    chk("dout_idle", 32'(dout[k]), 32'(d));
  endtask

  task automatic start(int k, bit isw, logic [7:0] a, logic [15:0] d);
    @(negedge clock);
    rd[k] = !isw;
    wr[k] = isw;
    ad[k] = a;
    di[k] = d;
    tick();
    chk("busy_req", 32'(bsy[k]), 1);
    chk("mfc_req", 32'(mfc[k]), 0);
  endtask

  // Waits out the latency while scrambling addr/data, which must be ignored
  task automatic complete(int k, bit isw, logic [7:0] a, logic [15:0] d);
    for (int i = 1; i <= lat[k]; i++) begin
      @(negedge clock);
      ad[k] = 8'($urandom);
      di[k] = 16'($urandom);
      tick();
      if (i < lat[k]) chk("mfc_early", 32'(mfc[k]), 0);
    end
    chk("mfc_rise", 32'(mfc[k]), 1);
    chk("busy_ack", 32'(bsy[k]), 1);
    if (isw) begin
      mem_m[k][a]   = d;
      valid_m[k][a] = 1'b1;
    end else begin
      dout_m[k] = mem_m[k][a];
    end
    chk("dout_ack", 32'(dout[k]), 32'(dout_m[k]));
  endtask

  task automatic hold(int k, int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("mfc_hold", 32'(mfc[k]), 1);
      chk("dout_hold", 32'(dout[k]), 32'(dout_m[k]));
    end
  endtask

  task automatic drop(int k);
    @(negedge clock);
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    tick();
    idle_outs(k, dout_m[k]);
  endtask

  task automatic txn(int k, bit isw, logic [7:0] a, logic [15:0] d, int h);
    start(k, isw, a, d);
    complete(k, isw, a, d);
    hold(k, h);
    drop(k);
  endtask

  task automatic pulse_reset(int k);
    @(negedge clock);
    rst[k] = 1'b1;
    rd[k]  = 1'b0;
    wr[k]  = 1'b0;
    tick();
    dout_m[k] = 16'h0;
    idle_outs(k, 16'h0);
    @(negedge clock);
    rst[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  a;
    logic [15:0] d;
    bit          isw;
    int          k;

    for (int j = 0; j < 2; j++) begin
      rst[j] = 1'b1; rd[j] = 1'b0; wr[j] = 1'b0;
      ad[j] = 8'h0; di[j] = 16'h0; dout_m[j] = 16'h0;
    end
    tick();
    tick();
    idle_outs(0, 16'h0);
    idle_outs(1, 16'h0);
    @(negedge clock);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Write then read at LATENCY 3
    txn(0, 1'b1, 8'h12, 16'hBEEF, 0);
    txn(0, 1'b0, 8'h12, 16'h0, 0);

    // Held read request
    txn(0, 1'b0, 8'h12, 16'h0, 5);

    // Abort in WAIT after a committed 0xAAAA
    txn(0, 1'b1, 8'h05, 16'hAAAA, 0);
    start(0, 1'b1, 8'h05, 16'h1234);
    tick();
    chk("abort_wait_mfc", 32'(mfc[0]), 0);
    chk("abort_wait_busy", 32'(bsy[0]), 1);
    @(negedge clock);
    wr[0] = 1'b0;
    tick();
    idle_outs(0, dout_m[0]);
    tick();
    tick();
    chk("abort_no_mfc", 32'(mfc[0]), 0);
    txn(0, 1'b0, 8'h05, 16'h0, 0);

    // Conflict for two cycles
    @(negedge clock);
    rd[0] = 1'b1; wr[0] = 1'b1; ad[0] = 8'h12; di[0] = 16'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("conf_err", 32'(er[0]), 1);
      chk("conf_busy", 32'(bsy[0]), 0);
      chk("conf_mfc", 32'(mfc[0]), 0);
    end
    @(negedge clock);
    rd[0] = 1'b0; wr[0] = 1'b0;
    tick();
    idle_outs(0, dout_m[0]);
    txn(0, 1'b0, 8'h12, 16'h0, 0);

    // Reset during WAIT drops the pending write
    txn(0, 1'b1, 8'h20, 16'h1111, 0);
    start(0, 1'b1, 8'h20, 16'h0F0F);
    pulse_reset(0);
    txn(0, 1'b0, 8'h20, 16'h0, 0);

    // Reset during ACK keeps the committed write
    start(0, 1'b1, 8'h21, 16'h2222);
    complete(0, 1'b1, 8'h21, 16'h2222);
    pulse_reset(0);
    txn(0, 1'b0, 8'h21, 16'h0, 0);

    // Back-to-back at LATENCY 1, top address
    txn(1, 1'b1, 8'hFF, 16'hC0DE, 0);
    txn(1, 1'b0, 8'hFF, 16'h0, 0);

    // Randomized traffic; reads only hit defined words
    for (int n = 0; n < 30; n++) begin
      k   = int'($urandom_range(0, 1));
      a   = 8'($urandom);
      d   = 16'($urandom);
      isw = !valid_m[k][a] || ($urandom_range(0, 1) == 1);
      txn(k, isw, a, d, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
